// File: rtl/dmg_core_if.sv
// rtl/dmg_core_if.sv - cartridge ROM read port shared by the DMG core and its ROM
interface dmg_core_if;
   logic [14:0] rom_addr;
   logic [7:0]  rom_data;

   modport master (output rom_addr, input rom_data);
   modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/dmg_core.sv
// rtl/dmg_core.sv - minimal SM83-subset CPU core fetching from a 1-cycle synchronous ROM
module dmg_core #(
   parameter logic [15:0] RESET_PC = 16'h0100
) (
   input  logic          clk,
   input  logic          rst,
   dmg_core_if.master    bus,
   output logic          halted,
   output logic [15:0]   dbg_pc,
   output logic [7:0]    dbg_a,
   output logic [7:0]    dbg_f
);

   // Each byte takes an address cycle and a data cycle
   localparam logic [0:0] S_ADDR = 1'b0;
   localparam logic [0:0] S_DATA = 1'b1;

   logic [0:0]  r_state;
   logic [1:0]  r_cnt;
   logic [7:0]  r_op;
   logic [7:0]  r_lo;
   logic [15:0] r_pc;
   logic [7:0]  r_regs [0:7];
   logic        r_z, r_n, r_h, r_c;
   logic        r_halted;

   logic [7:0]  w_op;
   logic [7:0]  w_imm;
   logic [1:0]  w_len;
   logic        w_last;
   logic        w_is_jr;
   logic        w_cond;
   logic [15:0] w_pc_inc;
   logic [15:0] w_tgt;
   logic [7:0]  w_src;
   logic [7:0]  w_dst;
   logic [7:0]  w_a;
   logic        w_cin;
   logic [8:0]  w_sum9;
   logic [4:0]  w_hsum5;
   logic [8:0]  w_dif9;
   logic [4:0]  w_hdif5;
   logic [7:0]  w_inc;
   logic [7:0]  w_dec;

   logic        w_wr_en;
   logic [2:0]  w_wr_idx;
   logic [7:0]  w_wr_val;
   logic        w_fl_en;
   logic        w_nz, w_nn, w_nh, w_nc;
   logic        w_jump;
   logic        w_halt;

   // The opcode is live on the ROM bus for the first byte, latched afterwards
   assign w_op     = (r_cnt == 2'd0) ? bus.rom_data : r_op;
   assign w_imm    = bus.rom_data;
   assign w_pc_inc = r_pc + 16'd1;
   assign w_is_jr  = (w_op == 8'h18) || ((w_op[7:5] == 3'b001) && (w_op[2:0] == 3'b000));
   assign w_src    = r_regs[w_op[2:0]];
   assign w_dst    = r_regs[w_op[5:3]];
   assign w_a      = r_regs[7];
   assign w_cin    = w_op[3] & ~w_op[5] & r_c;
   assign w_sum9   = {1'b0, w_a} + {1'b0, w_src} + {8'd0, w_cin};
   assign w_hsum5  = {1'b0, w_a[3:0]} + {1'b0, w_src[3:0]} + {4'd0, w_cin};
   assign w_dif9   = {1'b0, w_a} - {1'b0, w_src} - {8'd0, w_cin};
   assign w_hdif5  = {1'b0, w_a[3:0]} - {1'b0, w_src[3:0]} - {4'd0, w_cin};
   assign w_inc    = w_dst + 8'd1;
   assign w_dec    = w_dst - 8'd1;
   assign w_tgt    = (w_op == 8'hC3) ? {w_imm, r_lo}
                                     : w_pc_inc + {{8{w_imm[7]}}, w_imm};
   assign w_last   = ((r_cnt + 2'd1) == w_len);

   // Instruction length in bytes from the opcode
   always_comb begin
      w_len = 2'd1;
      if (w_op == 8'hC3)
         w_len = 2'd3;
      else if (w_is_jr || ((w_op[7:6] == 2'b00) && (w_op[2:0] == 3'd6) && (w_op[5:3] != 3'd6)))
         w_len = 2'd2;
   end

   // Branch condition for JR forms; the unconditional JR always jumps
   always_comb begin
      w_cond = 1'b1;
      if (w_op != 8'h18) begin
         case (w_op[4:3])
            2'd0:    w_cond = ~r_z;
            2'd1:    w_cond = r_z;
            2'd2:    w_cond = ~r_c;
            default: w_cond = r_c;
         endcase
      end
   end

   // Execute stage: what the last byte of the instruction commits
   always_comb begin
      w_wr_en  = 1'b0;
      w_wr_idx = w_op[5:3];
      w_wr_val = 8'h00;
      w_fl_en  = 1'b0;
      w_nz     = r_z;
      w_nn     = r_n;
      w_nh     = r_h;
      w_nc     = r_c;
      w_jump   = 1'b0;
      w_halt   = 1'b0;
      if (w_op == 8'h76) begin
         w_halt = 1'b1;
      end else if (w_op == 8'hC3) begin
         w_jump = 1'b1;
      end else if (w_is_jr) begin
         w_jump = w_cond;
      end else if ((w_op[7:6] == 2'b00) && (w_op[5:3] != 3'd6)) begin
         case (w_op[2:0])
            3'd6: begin
               w_wr_en  = 1'b1;
               w_wr_val = w_imm;
            end
            3'd4: begin
               w_wr_en  = 1'b1;
               w_wr_val = w_inc;
               w_fl_en  = 1'b1;
               w_nz     = (w_inc == 8'h00);
               w_nn     = 1'b0;
               w_nh     = (w_dst[3:0] == 4'hF);
            end
            3'd5: begin
               w_wr_en  = 1'b1;
               w_wr_val = w_dec;
               w_fl_en  = 1'b1;
               w_nz     = (w_dec == 8'h00);
               w_nn     = 1'b1;
               w_nh     = (w_dst[3:0] == 4'h0);
            end
            default: ;
         endcase
      end else if ((w_op[7:6] == 2'b01) && (w_op[5:3] != 3'd6) && (w_op[2:0] != 3'd6)) begin
         w_wr_en  = 1'b1;
         w_wr_val = w_src;
      end else if ((w_op[7:6] == 2'b10) && (w_op[2:0] != 3'd6)) begin
         w_wr_idx = 3'd7;
         w_fl_en  = 1'b1;
         case (w_op[5:3])
            3'd0, 3'd1: begin
               w_wr_en  = 1'b1;
               w_wr_val = w_sum9[7:0];
               w_nn     = 1'b0;
               w_nh     = w_hsum5[4];
               w_nc     = w_sum9[8];
            end
            3'd2, 3'd3, 3'd7: begin
               w_wr_en  = (w_op[5:3] != 3'd7);
               w_wr_val = w_dif9[7:0];
               w_nn     = 1'b1;
               w_nh     = w_hdif5[4];
               w_nc     = w_dif9[8];
            end
            3'd4: begin
               w_wr_en  = 1'b1;
               w_wr_val = w_a & w_src;
               w_nn     = 1'b0;
               w_nh     = 1'b1;
               w_nc     = 1'b0;
            end
            3'd5: begin
               w_wr_en  = 1'b1;
               w_wr_val = w_a ^ w_src;
               w_nn     = 1'b0;
               w_nh     = 1'b0;
               w_nc     = 1'b0;
            end
            default: begin
               w_wr_en  = 1'b1;
               w_wr_val = w_a | w_src;
               w_nn     = 1'b0;
               w_nh     = 1'b0;
               w_nc     = 1'b0;
            end
         endcase
         if (w_op[5:3] == 3'd7)
            w_nz = (w_dif9[7:0] == 8'h00);
         else
            w_nz = (w_wr_val == 8'h00);
      end
   end

   // Fetch sequencer and architectural state update
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= S_ADDR;
         r_cnt    <= 2'd0;
         r_op     <= 8'h00;
         r_lo     <= 8'h00;
         r_pc     <= RESET_PC;
         r_z      <= 1'b0;
         r_n      <= 1'b0;
         r_h      <= 1'b0;
         r_c      <= 1'b0;
         r_halted <= 1'b0;
         for (int i = 0; i < 8; i++)
            r_regs[i] <= 8'h00;
      end else if (!r_halted) begin
         if (r_state == S_ADDR) begin
            r_state <= S_DATA;
         end else begin
            r_state <= S_ADDR;
            r_pc    <= w_pc_inc;
            if (w_last) begin
               r_cnt <= 2'd0;
               if (w_wr_en)
                  r_regs[w_wr_idx] <= w_wr_val;
               if (w_fl_en) begin
                  r_z <= w_nz;
                  r_n <= w_nn;
                  r_h <= w_nh;
                  r_c <= w_nc;
               end
               if (w_jump)
                  r_pc <= w_tgt;
               if (w_halt)
                  r_halted <= 1'b1;
            end else begin
               r_cnt <= r_cnt + 2'd1;
               if (r_cnt == 2'd0)
                  r_op <= bus.rom_data;
               else
                  r_lo <= bus.rom_data;
            end
         end
      end
   end

   assign bus.rom_addr = r_pc[14:0];
   assign halted       = r_halted;
   assign dbg_pc       = r_pc;
   assign dbg_a        = r_regs[7];
   assign dbg_f        = {r_z, r_n, r_h, r_c, 4'b0000};

endmodule

// File: tb/tb_dmg_core.sv
// tb/tb_dmg_core.sv - randomized and directed self-checking bench for dmg_core
module tb_dmg_core;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        halted;
   logic [15:0] dbg_pc;
   logic [7:0]  dbg_a;
   logic [7:0]  dbg_f;

   dmg_core_if bus ();

   dmg_core #(.RESET_PC(16'h0100)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus.master),
      .halted (halted),
      .dbg_pc (dbg_pc),
      .dbg_a  (dbg_a),
      .dbg_f  (dbg_f)
   );

   always #5 clk = ~clk;

   // Synchronous cartridge ROM, one clock of read latency
   logic [7:0] rom [0:32767];
   always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic cmp(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Instruction-level model of the architecture
   logic [15:0] m_pc;
   logic [7:0]  m_r [8];
   logic        m_z, m_n, m_h, m_c, m_halt;

   function automatic logic [7:0] m_f();
      return {m_z, m_n, m_h, m_c, 4'b0000};
   endfunction

   task automatic m_reset();
      m_pc = 16'h0100;
      for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
      m_z = 0; m_n = 0; m_h = 0; m_c = 0; m_halt = 0;
   endtask

   task automatic m_fetch(output logic [7:0] b);
      b = rom[m_pc[14:0]];
      m_pc = m_pc + 16'd1;
   endtask

   task automatic m_step(output int len);
      logic [7:0] op, b1, b2;
      int a, b, cin, res, grp, d, s;
      logic take;
      m_fetch(op);
      len = 1;
      grp = int'(op[7:6]);
      d = int'(op[5:3]);
      s = int'(op[2:0]);
      if (op == 8'h76) begin
         m_halt = 1;
      end else if (op == 8'hC3) begin
         m_fetch(b1); m_fetch(b2); len = 3;
         m_pc = {b2, b1};
      end else if (op == 8'h18 || op == 8'h20 || op == 8'h28 || op == 8'h30 || op == 8'h38) begin
         m_fetch(b1); len = 2;
         case (op)
            8'h20:   take = !m_z;
            8'h28:   take = m_z;
            8'h30:   take = !m_c;
            8'h38:   take = m_c;
            default: take = 1;
         endcase
         if (take) m_pc = m_pc + {{8{b1[7]}}, b1};
      end else if (grp == 0 && d != 6 && s == 6) begin
         m_fetch(b1); len = 2;
         m_r[d] = b1;
      end else if (grp == 0 && d != 6 && s == 4) begin
         a = int'(m_r[d]);
         m_h = ((a % 16) + 1) > 15;
         m_r[d] = 8'((a + 1) % 256);
         m_z = (m_r[d] == 0); m_n = 0;
      end else if (grp == 0 && d != 6 && s == 5) begin
         a = int'(m_r[d]);
         m_h = ((a % 16) - 1) < 0;
         m_r[d] = 8'((a + 255) % 256);
         m_z = (m_r[d] == 0); m_n = 1;
      end else if (grp == 1 && d != 6 && s != 6) begin
         m_r[d] = m_r[s];
      end else if (grp == 2 && s != 6) begin
         a = int'(m_r[7]);
         b = int'(m_r[s]);
         cin = (d == 1 || d == 3) ? int'(m_c) : 0;
         if (d == 0 || d == 1) begin
            res = a + b + cin;
            m_h = ((a % 16) + (b % 16) + cin) > 15;
            m_c = res > 255; m_n = 0;
            res = res % 256;
         end else if (d == 2 || d == 3 || d == 7) begin
            res = a - b - cin;
            m_h = ((a % 16) - (b % 16) - cin) < 0;
            m_c = res < 0; m_n = 1;
            res = (res + 256) % 256;
         end else begin
            res = (d == 4) ? (a & b) : (d == 5) ? (a ^ b) : (a | b);
            m_h = (d == 4); m_c = 0; m_n = 0;
         end
         m_z = (res == 0);
         if (d != 7) m_r[7] = 8'(res);
      end
   endtask

   // Per-cycle expectations derived from the model
   logic        chk_en = 0;
   logic [15:0] exp_pc = 16'h0100;
   logic [7:0]  exp_a = 0, exp_f = 0;
   logic        exp_halt = 0;
   logic        in_ins = 0;
   logic [15:0] st_pc;
   logic [7:0]  st_a, st_f;
   int          ins_len, ins_j;

   always @(negedge clk) begin
      if (chk_en) begin
         cmp("rom_addr", {1'b0, bus.rom_addr}, {1'b0, exp_pc[14:0]});
         cmp("dbg_pc", dbg_pc, exp_pc);
         cmp("dbg_a", {8'h00, dbg_a}, {8'h00, exp_a});
         cmp("dbg_f", {8'h00, dbg_f}, {8'h00, exp_f});
         cmp("halted", {15'd0, halted}, {15'd0, exp_halt});
      end
   end

   task automatic tick();
      @(posedge clk);
      if (!rst) begin
         m_reset();
         in_ins = 0;
         exp_pc = m_pc; exp_a = 0; exp_f = 0; exp_halt = 0;
      end else if (!exp_halt) begin
         if (!in_ins) begin
            st_pc = m_pc; st_a = m_r[7]; st_f = m_f();
            m_step(ins_len);
            ins_j = 0; in_ins = 1;
         end
         ins_j++;
         if (ins_j == 2 * ins_len) begin
            exp_pc = m_pc; exp_a = m_r[7]; exp_f = m_f(); exp_halt = m_halt;
            in_ins = 0;
         end else begin
            exp_pc = st_pc + 16'(ins_j / 2);
            exp_a = st_a; exp_f = st_f;
         end
      end
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   logic [7:0] prog [$];

   // Hold reset while the ROM image is swapped, then release
   task automatic load_prog(input logic [15:0] at);
      rst = 0;
      tick();
      for (int i = 0; i < 32768; i++) rom[i] = 8'h00;
      for (int i = 0; i < prog.size(); i++) rom[(int'(at) + i) % 32768] = prog[i];
      tick();
      rst = 1;
   endtask

   task automatic run_to_halt(input string name, input int max);
      int n = 0;
      while (!halted && n < max) begin
         tick();
         n++;
      end
      cmp({name, "_halt_reached"}, {15'd0, halted}, 16'd1);
   endtask

   task automatic lit_prog(input string name, input logic [7:0] a, input logic [7:0] f, input logic [15:0] pc);
      run_to_halt(name, 200);
      cmp({name, "_a"}, {8'h00, dbg_a}, {8'h00, a});
      cmp({name, "_f"}, {8'h00, dbg_f}, {8'h00, f});
      cmp({name, "_pc"}, dbg_pc, pc);
      cmp({name, "_model_a"}, {8'h00, m_r[7]}, {8'h00, a});
      cmp({name, "_model_f"}, {8'h00, m_f()}, {8'h00, f});
   endtask

   function automatic logic [7:0] rand_byte();
      int r = $urandom_range(0, 99);
      logic [7:0] b;
      b = 8'($urandom);
      if (r < 15)      b = {2'b00, b[2:0], 3'b110};
      else if (r < 30) b = {2'b00, b[2:0], 2'b10, b[3]};
      else if (r < 45) b = {2'b01, b[5:0]};
      else if (r < 70) b = {2'b10, b[5:0]};
      else if (r < 78) b = {3'b001, b[1:0], 3'b000};
      else if (r < 80) b = 8'h18;
      else if (r < 81) b = 8'hC3;
      else if (r == 99) b = 8'h76;
      if (r != 99 && b == 8'h76) b = 8'h00;
      return b;
   endfunction

   int seen_a, seen_b, bad_loop;

   initial begin
      for (int i = 0; i < 32768; i++) rom[i] = 8'h00;
      rst = 0;
      m_reset();
      tick();
      chk_en = 1;
      tick();
      cmp("reset_pc", dbg_pc, 16'h0100);
      cmp("reset_addr", {1'b0, bus.rom_addr}, 16'h0100);
      cmp("reset_a", {8'h00, dbg_a}, 16'h0000);
      cmp("reset_f", {8'h00, dbg_f}, 16'h0000);
      cmp("reset_halted", {15'd0, halted}, 16'd0);
      rst = 1;
      ticks(2);
      cmp("first_nop_addr", {1'b0, bus.rom_addr}, 16'h0101);

      prog = '{8'h00, 8'hC3, 8'h50, 8'h01};
      load_prog(16'h0100);
      ticks(8);
      cmp("jp_addr", {1'b0, bus.rom_addr}, 16'h0150);
      rst = 0; tick(); rst = 1;
      ticks(7);
      rst = 0; tick();
      cmp("jp_abort_pc", dbg_pc, 16'h0100);
      cmp("jp_abort_addr", {1'b0, bus.rom_addr}, 16'h0100);
      rst = 1;
      ticks(8);
      cmp("jp_retry_addr", {1'b0, bus.rom_addr}, 16'h0150);

      prog = '{8'h3E, 8'h3C, 8'h3C, 8'h76};
      load_prog(16'h0100); lit_prog("inc_a", 8'h3D, 8'h00, 16'h0104);
      prog = '{8'h06, 8'hFF, 8'h04, 8'h78, 8'h76};
      load_prog(16'h0100); lit_prog("inc_b", 8'h00, 8'hA0, 16'h0105);
      prog = '{8'h3E, 8'h01, 8'h3D, 8'h76};
      load_prog(16'h0100); lit_prog("dec_a", 8'h00, 8'hC0, 16'h0104);
      prog = '{8'h3E, 8'hF0, 8'h06, 8'h20, 8'h80, 8'h76};
      load_prog(16'h0100); lit_prog("add", 8'h10, 8'h10, 16'h0106);
      prog = '{8'h3E, 8'h05, 8'h06, 8'h05, 8'h90, 8'h76};
      load_prog(16'h0100); lit_prog("sub", 8'h00, 8'hC0, 16'h0106);
      prog = '{8'hAF, 8'h76};
      load_prog(16'h0100); lit_prog("xor", 8'h00, 8'h80, 16'h0102);
      prog = '{8'h3E, 8'h03, 8'hFE, 8'h76};
      load_prog(16'h0100); lit_prog("unsupported", 8'h03, 8'h00, 16'h0104);
      prog = '{8'hAF, 8'h20, 8'h05, 8'h76};
      load_prog(16'h0100); lit_prog("jrnz_not_taken", 8'h00, 8'h80, 16'h0104);

      prog = '{8'h18, 8'h80};
      load_prog(16'h0100);
      rom[16'h0082] = 8'h76;
      lit_prog("jr_back", 8'h00, 8'h00, 16'h0083);

      prog = '{8'hAF, 8'h28, 8'hFE};
      load_prog(16'h0100);
      ticks(6);
      seen_a = 0; seen_b = 0; bad_loop = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.rom_addr == 15'h0101) seen_a++;
         else if (bus.rom_addr == 15'h0102) seen_b++;
         else bad_loop++;
      end
      cmp("jrz_loop_other_addr", 16'(bad_loop), 16'd0);
      cmp("jrz_loop_both_addrs", {15'd0, (seen_a > 0) && (seen_b > 0)}, 16'd1);

      prog = '{8'h3E, 8'h77, 8'h76};
      load_prog(16'h0100);
      lit_prog("halt", 8'h77, 8'h00, 16'h0103);
      bad_loop = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.rom_addr != 15'h0103) bad_loop++;
      end
      cmp("halt_frozen", 16'(bad_loop), 16'd0);
      rst = 0; tick(); rst = 1;
      cmp("halt_cleared", {15'd0, halted}, 16'd0);
      cmp("halt_restart_pc", dbg_pc, 16'h0100);

      for (int run = 0; run < 5; run++) begin
         int rst_at;
         rst = 0; tick();
         for (int i = 0; i < 32768; i++) rom[i] = rand_byte();
         tick(); rst = 1;
         rst_at = $urandom_range(100, 1400);
         for (int i = 0; i < 1500; i++) begin
            if (i == rst_at) rst = 0;
            tick();
            rst = 1;
         end
      end

      chk_en = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
